// File: rtl/tc_sram_arb_pkg.sv
// tc_sram_arb_pkg: response entry type and one-hot helper shared by the SRAM port arbiter
package tc_sram_arb_pkg;
  localparam int MaxReq = 256;
  localparam int RspIdxWidth = $clog2(MaxReq);
  typedef struct packed {
    logic                   valid;
    logic [RspIdxWidth-1:0] idx;
  } rsp_entry_t;
  function automatic logic [MaxReq-1:0] idx_to_onehot(input logic [RspIdxWidth-1:0] idx);
    return MaxReq'(1) << idx;
  endfunction
endpackage

// File: rtl/tc_sram_arb_rsp_pipe.sv
// tc_sram_arb_rsp_pipe: carries granted-read requester indices through the SRAM latency, Latency=0 bypasses
module tc_sram_arb_rsp_pipe
  import tc_sram_arb_pkg::*;
#(
  parameter int NumReq  = 4,
  parameter int Latency = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  rsp_entry_t        rsp_i,
  output logic [NumReq-1:0] rvalid_o
);
  rsp_entry_t head;
  if (Latency == 0) begin : g_bypass
    assign head = rsp_i;
  end else begin : g_pipe
    rsp_entry_t stage_q [Latency];
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < Latency; i++) stage_q[i] <= '0;
      end else begin
        stage_q[Latency-1] <= rsp_i;
        for (int i = 0; i < Latency - 1; i++) stage_q[i] <= stage_q[i+1];
      end
    end
    assign head = stage_q[0];
  end
  assign rvalid_o = head.valid ? NumReq'(idx_to_onehot(head.idx)) : '0;
endmodule

// File: rtl/tc_sram_port_arbiter.sv
// tc_sram_port_arbiter: shares one tc_sram port among NumReq requesters; TC_SRAM_ARB_RR_EN selects round-robin
module tc_sram_port_arbiter
  import tc_sram_arb_pkg::*;
#(
  parameter  int NumReq    = 4,
  parameter  int NumWords  = 1024,
  parameter  int DataWidth = 32,
  parameter  int ByteWidth = 8,
  parameter  int Latency   = 1,
  localparam int AddrWidth = NumWords > 1 ? $clog2(NumWords) : 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int IdxWidth  = NumReq > 1 ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [AddrWidth-1:0]          sram_addr_o,
  output logic [DataWidth-1:0]          sram_wdata_o,
  output logic [BeWidth-1:0]            sram_be_o,
  input  logic [DataWidth-1:0]          sram_rdata_i
);
  logic [IdxWidth-1:0] win;
  logic                acc;
  rsp_entry_t          rsp;
  assign acc = |req_i & ~rst_i;
  if (NumReq == 1) begin : g_single
    assign win = '0;
  end else begin : g_multi
`ifdef TC_SRAM_ARB_RR_EN
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    assign ptr_d = (win == IdxWidth'(NumReq - 1)) ? '0 : win + 1'b1;
    always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else if (acc) ptr_q <= ptr_d;
    end
    // Descending offset scan so the request closest after ptr_q is assigned last and wins
    always_comb begin
      win = '0;
      for (int o = NumReq - 1; o >= 0; o--)
        if (req_i[(int'(ptr_q) + o) % NumReq]) win = IdxWidth'((int'(ptr_q) + o) % NumReq);
    end
`else
    always_comb begin
      win = '0;
      for (int k = NumReq - 1; k >= 0; k--)
        if (req_i[k]) win = IdxWidth'(k);
    end
`endif
  end
  assign gnt_o        = acc ? NumReq'(idx_to_onehot(RspIdxWidth'(win))) : '0;
  assign sram_req_o   = acc;
  assign sram_we_o    = acc & we_i[win];
  assign sram_addr_o  = acc ? addr_i[win*AddrWidth +: AddrWidth] : '0;
  assign sram_wdata_o = acc ? wdata_i[win*DataWidth +: DataWidth] : '0;
  assign sram_be_o    = acc ? be_i[win*BeWidth +: BeWidth] : '0;
  assign rsp          = {acc & ~sram_we_o, RspIdxWidth'(win)};
  assign rdata_o      = sram_rdata_i;
  tc_sram_arb_rsp_pipe #(
    .NumReq  (NumReq),
    .Latency (Latency)
  ) u_rsp_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rsp_i    (rsp),
    .rvalid_o (rvalid_o)
  );
endmodule

// File: tb/tb_tc_sram_port_arbiter.sv
// tb_tc_sram_port_arbiter: randomized and directed checks of the arbiter against a transaction-level model
module tb_tc_sram_port_arbiter;
  localparam int N = 4, WORDS = 1024, DW = 32, AW = 10, BW = 4, LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_i, we_i, gnt_o, rvalid_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*BW-1:0] be_i;
  logic [DW-1:0] rdata_o, sram_wdata_o, sram_rdata_i;
  logic sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [BW-1:0] sram_be_o;
  logic r_req [N], r_we [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wdata [N];
  logic [BW-1:0] r_be [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_i[g] = r_req[g];
    assign we_i[g] = r_we[g];
    assign addr_i[g*AW +: AW] = r_addr[g];
    assign wdata_i[g*DW +: DW] = r_wdata[g];
    assign be_i[g*BW +: BW] = r_be[g];
  end
  tc_sram_port_arbiter #(
    .NumReq(N), .NumWords(WORDS), .DataWidth(DW), .ByteWidth(8), .Latency(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );
  // Single-port SRAM stand-in with LAT cycles of read latency
  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] sp [LAT];
  always @(posedge clk) begin
    if (sram_req_o && sram_we_o)
      for (int b = 0; b < BW; b++) if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
    sp[LAT-1] <= mem[sram_addr_o];
    for (int i = 0; i < LAT - 1; i++) sp[i] <= sp[i+1];
  end
  assign sram_rdata_i = sp[0];
  // Reference model: memory contents, priority pointer, and responses keyed by due cycle
  int checks = 0, errors = 0, cyc = 0, ptr = 0, m_win = -1;
  logic [DW-1:0] ref_mem [WORDS];
  logic [N-1:0] exp_rv_q [int];
  logic [DW-1:0] exp_rd_q [int];
  logic [N-1:0] e_gnt, e_rv;
  logic e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd;
  logic [BW-1:0] e_be;
  task automatic model_eval();
    int start;
`ifdef TC_SRAM_ARB_RR_EN
    start = ptr;
`else
    start = 0;
`endif
    m_win = -1;
    if (!rst)
      for (int o = 0; o < N; o++)
        if (r_req[(start + o) % N]) begin m_win = (start + o) % N; break; end
    if (m_win < 0) begin
      e_gnt = '0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    end else begin
      e_gnt = N'(1) << m_win; e_we = r_we[m_win]; e_addr = r_addr[m_win];
      e_wdata = r_wdata[m_win]; e_be = r_be[m_win];
    end
    e_rv = exp_rv_q.exists(cyc) ? exp_rv_q[cyc] : '0;
    e_rd = exp_rd_q.exists(cyc) ? exp_rd_q[cyc] : '0;
  endtask
  task automatic advance();
    int keys[$];
    if (rst) begin
      ptr = 0;
      foreach (exp_rv_q[c]) if (c > cyc) keys.push_back(c);
      foreach (keys[i]) begin exp_rv_q.delete(keys[i]); exp_rd_q.delete(keys[i]); end
    end else if (m_win >= 0) begin
      ptr = (m_win + 1) % N;
      if (r_we[m_win]) begin
        for (int b = 0; b < BW; b++)
          if (r_be[m_win][b]) ref_mem[r_addr[m_win]][b*8 +: 8] = r_wdata[m_win][b*8 +: 8];
      end else begin
        exp_rv_q[cyc + LAT] = e_gnt;
        exp_rd_q[cyc + LAT] = ref_mem[r_addr[m_win]];
      end
    end
    @(posedge clk); #1; cyc++;
  endtask
  task automatic clear_reqs();
    for (int k = 0; k < N; k++) r_req[k] = 1'b0;
  endtask
  task automatic quiet_reset();
    rst = 1'b1; model_eval(); advance(); rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) r_req[k] = 1'b1;
    model_eval(); advance();
    repeat (3) begin
      @(negedge clk); model_eval();
      checks++;
      if (gnt_o !== '0 || sram_req_o !== 1'b0 || rvalid_o !== '0) begin
        errors++; $display("FAIL reset: gnt=%b sram_req=%b rvalid=%b, expected all zero", gnt_o, sram_req_o, rvalid_o);
      end
      advance();
    end
    clear_reqs(); rst = 1'b0;
  endtask
  task automatic test_isolated_read();
    r_req[2] = 1'b1; r_we[2] = 1'b1; r_addr[2] = 10'h10; r_wdata[2] = 32'hDEADBEEF; r_be[2] = 4'hF;
    for (int c = 0; c < 2 + LAT; c++) begin
      if (c == 1) r_we[2] = 1'b0;
      if (c == 2) r_req[2] = 1'b0;
      @(negedge clk); model_eval();
      if (c < 2) begin
        checks++;
        if (gnt_o !== 4'b0100) begin errors++; $display("FAIL iso_gnt c%0d: got %b want 0100", c, gnt_o); end
      end else begin
        checks++;
        if (rvalid_o !== (c == 1 + LAT ? 4'b0100 : 4'b0000)) begin
          errors++; $display("FAIL iso_rvalid c%0d: got %b", c, rvalid_o);
        end
        if (c == 1 + LAT) begin
          checks++;
          if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL iso_rdata: got %h want deadbeef", rdata_o); end
        end
      end
      advance();
    end
  endtask
  task automatic test_fairness();
    int w;
    quiet_reset();
    for (int k = 0; k < N; k++) begin
      r_req[k] = 1'b1; r_we[k] = 1'b0; r_addr[k] = AW'(k + 32); r_be[k] = 4'hF;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); model_eval();
`ifdef TC_SRAM_ARB_RR_EN
      w = i % N;
`else
      w = 0;
`endif
      checks++;
      if (gnt_o !== (4'b0001 << w)) begin errors++; $display("FAIL fair_gnt i%0d: got %b want %b", i, gnt_o, 4'b0001 << w); end
      checks++;
      if (rvalid_o !== e_rv) begin errors++; $display("FAIL fair_rvalid i%0d: got %b want %b", i, rvalid_o, e_rv); end
      advance();
    end
    clear_reqs();
    repeat (LAT + 1) begin
      @(negedge clk); model_eval();
      checks++;
      if (rvalid_o !== e_rv || (e_rv != 0 && rdata_o !== e_rd)) begin
        errors++; $display("FAIL fair_drain: rvalid=%b rdata=%h want %b %h", rvalid_o, rdata_o, e_rv, e_rd);
      end
      advance();
    end
  endtask
  task automatic test_write_read();
    logic [DW-1:0] wd [3] = '{32'hAAAAAAAA, 32'h12345678, 32'h0};
    logic [BW-1:0] bt [3] = '{4'hF, 4'b0011, 4'hF};
    for (int c = 0; c < 3 + LAT; c++) begin
      r_req[1] = c < 3; r_we[1] = c < 2; r_addr[1] = 10'h5;
      if (c < 3) begin r_wdata[1] = wd[c]; r_be[1] = bt[c]; end
      @(negedge clk); model_eval();
      checks++;
      if (rvalid_o !== (c == 2 + LAT ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL wr_rvalid c%0d: got %b", c, rvalid_o); end
      if (c == 1) begin
        checks++;
        if (!sram_we_o || sram_be_o !== 4'b0011 || sram_wdata_o !== 32'h12345678 || sram_addr_o !== 10'h5) begin
          errors++; $display("FAIL wr_fields: we=%b be=%b wdata=%h addr=%h", sram_we_o, sram_be_o, sram_wdata_o, sram_addr_o);
        end
      end
      if (c == 2 + LAT) begin
        checks++;
        if (rdata_o !== 32'hAAAA5678) begin errors++; $display("FAIL wr_rdata: got %h want aaaa5678", rdata_o); end
      end
      advance();
    end
    clear_reqs();
  endtask
  task automatic test_back_to_back();
    int who [3] = '{0, 3, 1};
    for (int c = 0; c < 3 + LAT; c++) begin
      clear_reqs();
      if (c < 3) begin
        r_req[who[c]] = 1'b1; r_we[who[c]] = 1'b0; r_addr[who[c]] = AW'($urandom_range(15));
      end
      @(negedge clk); model_eval();
      checks++;
      if (rvalid_o !== ((c >= LAT) ? 4'b0001 << who[c-LAT] : 4'b0000)) begin
        errors++; $display("FAIL b2b_rvalid c%0d: got %b", c, rvalid_o);
      end
      if (c >= LAT) begin
        checks++;
        if (rdata_o !== e_rd) begin errors++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, rdata_o, e_rd); end
      end
      advance();
    end
    clear_reqs();
  endtask
  task automatic test_reset_midflight();
    for (int c = 0; c < 5; c++) begin
      clear_reqs(); rst = c == 1;
      if (c == 0) begin r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 10'h3; end
      if (c == 1) r_req[3] = 1'b1;
      if (c == 4) for (int k = 0; k < N; k++) begin r_req[k] = 1'b1; r_we[k] = 1'b1; r_be[k] = 4'h0; end
      @(negedge clk); model_eval();
      checks++;
      if (gnt_o !== (c == 0 ? 4'b0010 : c == 4 ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL rstmid_gnt c%0d: got %b", c, gnt_o);
      end
      checks++;
      if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL rstmid_rvalid c%0d: got %b want 0000", c, rvalid_o); end
      advance();
    end
    clear_reqs(); rst = 1'b0;
  endtask
  task automatic test_random();
    int w;
    for (int c = 0; c < 400 + LAT + 1; c++) begin
      for (int k = 0; k < N; k++)
        if (c < 400 && !r_req[k] && $urandom_range(2) == 0) begin
          r_req[k] = 1'b1; r_we[k] = 1'($urandom_range(1)); r_addr[k] = AW'($urandom_range(15));
          r_wdata[k] = $urandom; r_be[k] = BW'($urandom_range(15));
        end
      @(negedge clk); model_eval();
      checks++;
      if (gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt_o, e_gnt); end
      checks++;
      if (sram_req_o !== (e_gnt != 0) || sram_we_o !== e_we || sram_addr_o !== e_addr || sram_wdata_o !== e_wdata || sram_be_o !== e_be) begin
        errors++; $display("FAIL rnd_fields c%0d: req=%b we=%b addr=%h wdata=%h be=%b want %b %b %h %h %b", c,
          sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, e_gnt != 0, e_we, e_addr, e_wdata, e_be);
      end
      checks++;
      if (rvalid_o !== e_rv) begin errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid_o, e_rv); end
      if (e_rv != 0) begin
        checks++;
        if (rdata_o !== e_rd) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata_o, e_rd); end
      end
      w = m_win;
      advance();
      if (w >= 0) r_req[w] = 1'b0;
    end
  endtask
  initial begin
    for (int a = 0; a < WORDS; a++) begin mem[a] = $urandom; ref_mem[a] = mem[a]; end
    for (int k = 0; k < N; k++) begin
      r_req[k] = 1'b0; r_we[k] = 1'b0; r_addr[k] = '0; r_wdata[k] = '0; r_be[k] = '0;
    end
    test_reset();
    test_isolated_read();
    test_fairness();
    test_write_read();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
